ann_layer_engine: RTL and testbench
===================================

Name: ann_layer_engine

Overview:
- Parametrised successor to the fixed 64-input x 16-output classifier.
- Loads an N_IN-pixel image over a valid/ready stream, then requests one neuron's coefficient row at a time (N_IN weights, then a bias) over a second stream.
- Each row is multiply-accumulated into a signed score, and a running argmax is kept.
- Reports the winning class index and its score; sits between the image/weight loader and the display driver.

Parameters:
- N_IN, 64, pixels per image and weights per neuron (>=2)
- N_OUT, 16, output neurons/classes (>=2)
- DATA_W, 16, signed pixel/weight/bias width
- FRAC_W, 8, fractional bits of the bias; the bias is left-shifted by FRAC_W before it is added
- ACC_W, 40, signed accumulator/score width; must be >= 2*DATA_W+$clog2(N_IN)+1, elaboration-time assertion

Ports:
- clk  in  1  clock
- rst  in  1  reset (asynchronous, active-high)
- start  in  1  begin a pass; sampled only in IDLE
- pix_valid  in  1  pixel word valid
- pix_ready  out  1  engine accepts a pixel
- pix_data  in  DATA_W  signed pixel
- coef_valid  in  1  coefficient word valid
- coef_ready  out  1  engine accepts a coefficient
- coef_data  in  DATA_W  signed weight or bias
- request_coef  out  1  high while coefficients for neuron coef_select are wanted
- coef_select  out  $clog2(N_OUT)  neuron currently being computed
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse when a pass completes
- class_idx  out  $clog2(N_OUT)  winning neuron; held until the next done
- class_score  out  ACC_W  winning score; held until the next done

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-high. rst forces state to IDLE, clears all counters and the accumulator, and drives every output to 0. The pixel buffer contents are not reset.
- Handshake: a transfer occurs on a rising edge where valid&&ready. ready does not depend combinationally on valid. Upstream holds data stable while valid is high and ready is low.
- IDLE: all readies low. start=1 moves to LOAD_IMG on the next edge.
- LOAD_IMG: pix_ready=1. Each transfer writes buf[pix_cnt] and increments pix_cnt. After transfer N_IN-1, pix_ready drops and the state moves to ACCUM with neuron=0 and the accumulator cleared. Extra pixels are never accepted.
- ACCUM: request_coef=1, coef_ready=1, coef_select=neuron.
  - Transfer k (0..N_IN-1): acc <= acc + buf[k]*coef_data, exact signed product, sign-extended to ACC_W.
  - Transfer N_IN (bias): score <= acc + (sext(coef_data) <<< FRAC_W), then move to COMPARE.
- COMPARE (1 cycle, readies low):
  - If neuron==0 or score > best (strictly greater, signed), then best <= score and best_idx <= neuron. Ties keep the lower index.
  - If neuron==N_OUT-1, move to DONE; otherwise neuron++, clear acc, return to ACCUM.
- DONE (1 cycle): done=1; class_idx/class_score load best_idx/best; move to IDLE.
- Latency: with no stalls, done is high for the cycle following the edge N_IN + N_OUT*(N_IN+2) edges after the start-sampling edge. This is 1120 for the defaults.
- Boundary conditions:
  - start while busy is ignored.
  - rst mid-pass aborts immediately; the next start begins a clean pass.
  - Stalls (valid low) freeze all state.
  - pix_cnt and the coefficient counter never wrap; they compare against N_IN-1 and N_IN.

Optional Feature:
- Macro: ANN_SEVEN_SEG_EN.
- Defined: adds output seven_seg [7:0], active-high segments {dp,g,f,e,d,c,b,a}. It shows the hex digit of class_idx[3:0], is registered, and updates on the same edge as class_idx. dp is lit while busy. Reset value 8'h00.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package ann_pkg holds:
  - the state enum (IDLE, LOAD_IMG, ACCUM, COMPARE, DONE)
  - a width-check function for ACC_W
  - the hex-to-seven-segment constant table
- Sub-module ann_mac_unit: signed multiply, accumulate, clear, and bias-align/add. Parametrised by DATA_W, FRAC_W and ACC_W.

Test Plan:
- All pixels 1, all weights 1, biases 0, no stalls -> every score 64; done at edge 1120; class_idx=0 (tie rule); class_score=64.
- As above, but neuron 5 weights = 2 -> class_idx=5, class_score=128.
- All weights -1; bias 1 for neuron 15 only, 0 elsewhere -> scores -64 except neuron 15 = -64+256=192; class_idx=15, class_score=192.
- Scenario 2 with coef_valid and pix_valid toggling every other cycle -> identical result. request_coef is high throughout each ACCUM; coef_select steps 0..15.
- rst pulse after 10 coefficients of neuron 3 -> all outputs 0 and state IDLE within the same cycle. A fresh pass then reproduces scenario 1.
- start pulsed during ACCUM -> no effect, exactly one done. With ANN_SEVEN_SEG_EN and scenario 2 -> seven_seg=8'h6D ("5") after done.

Source files
------------

// File: rtl/ann_pkg.sv
// Shared types and constants for the ANN layer engine.
// The seven-segment table is only consumed when ANN_SEVEN_SEG_EN is defined.
package ann_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_IMG,
        ACCUM,
        COMPARE,
        DONE
    } state_t;

    // Accumulator must hold N_IN full-width products plus a sign bit without overflow.
    function automatic bit acc_w_ok(input int acc_w, input int data_w, input int n_in);
        return acc_w >= 2 * data_w + $clog2(n_in) + 1;
    endfunction

    // Segments {g,f,e,d,c,b,a} for hex digits, index 0 is the rightmost entry.
    localparam logic [15:0][6:0] SEG_HEX = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

endpackage

// File: rtl/ann_layer_engine_mac.sv
// Signed multiply-accumulate with clear, plus bias alignment for the final score.
// The biased sum is combinational; the caller registers it on the bias transfer.
module ann_mac_unit #(
    parameter int DATA_W = 16,
    parameter int FRAC_W = 8,
    parameter int ACC_W  = 40
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              mac_en,
    input  logic [DATA_W-1:0] pix,
    input  logic [DATA_W-1:0] coef,
    output logic [ACC_W-1:0]  biased
);

    logic signed [2*DATA_W-1:0] prod;
    logic        [ACC_W-1:0]    prod_ext;
    logic        [ACC_W-1:0]    bias_ext;
    logic        [ACC_W-1:0]    acc;

    assign prod     = $signed(pix) * $signed(coef);
    assign prod_ext = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
    assign bias_ext = {{(ACC_W-DATA_W){coef[DATA_W-1]}}, coef};
    assign biased   = acc + (bias_ext << FRAC_W);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            acc <= '0;
        else if (clr)
            acc <= '0;
        else if (mac_en)
            acc <= acc + prod_ext;
    end

endmodule

// File: rtl/ann_layer_engine.sv
// Fully-connected layer with running argmax: loads an image, then scores each neuron in turn.
// Optional build macro ANN_SEVEN_SEG_EN adds a registered seven-segment display of class_idx.
module ann_layer_engine
    import ann_pkg::*;
#(
    parameter int N_IN   = 64,
    parameter int N_OUT  = 16,
    parameter int DATA_W = 16,
    parameter int FRAC_W = 8,
    parameter int ACC_W  = 40
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     pix_valid,
    output logic                     pix_ready,
    input  logic [DATA_W-1:0]        pix_data,
    input  logic                     coef_valid,
    output logic                     coef_ready,
    input  logic [DATA_W-1:0]        coef_data,
    output logic                     request_coef,
    output logic [$clog2(N_OUT)-1:0] coef_select,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(N_OUT)-1:0] class_idx,
    output logic [ACC_W-1:0]         class_score
`ifdef ANN_SEVEN_SEG_EN
    ,
    output logic [7:0]               seven_seg
`endif
);

    localparam int PW = $clog2(N_IN);
    localparam int CW = $clog2(N_IN + 1);
    localparam int NW = $clog2(N_OUT);
    localparam logic [PW-1:0] PIX_LAST  = PW'(N_IN - 1);
    localparam logic [CW-1:0] COEF_LAST = CW'(N_IN);
    localparam logic [NW-1:0] N_LAST    = NW'(N_OUT - 1);

    if (!acc_w_ok(ACC_W, DATA_W, N_IN)) begin : g_acc_w_chk
        $error("ann_layer_engine: ACC_W too narrow for DATA_W and N_IN");
    end

    state_t            state, next_state;
    logic [PW-1:0]     pix_cnt;
    logic [CW-1:0]     coef_cnt;
    logic [NW-1:0]     neuron;
    logic [ACC_W-1:0]  score, best, biased;
    logic [NW-1:0]     best_idx;
    logic [DATA_W-1:0] pix_buf [N_IN];
    logic              pix_xfer, coef_xfer, is_bias, pix_last;

    assign pix_xfer    = pix_valid & pix_ready;
    assign coef_xfer   = coef_valid & coef_ready;
    assign is_bias     = (coef_cnt == COEF_LAST);
    assign pix_last    = (pix_cnt == PIX_LAST);
    assign coef_select = neuron;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state   = state;
        pix_ready    = 1'b0;
        coef_ready   = 1'b0;
        request_coef = 1'b0;
        done         = 1'b0;
        busy         = (state != IDLE);
        case (state)
            IDLE:     if (start) next_state = LOAD_IMG;
            LOAD_IMG: begin
                pix_ready = 1'b1;
                if (pix_valid && pix_last) next_state = ACCUM;
            end
            ACCUM: begin
                coef_ready   = 1'b1;
                request_coef = 1'b1;
                if (coef_valid && is_bias) next_state = COMPARE;
            end
            COMPARE:  next_state = (neuron == N_LAST) ? DONE : ACCUM;
            DONE: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default:  next_state = IDLE;
        endcase
    end

    // Image storage carries no reset; every pass overwrites it before use.
    always_ff @(posedge clk) begin
        if (pix_xfer)
            pix_buf[pix_cnt] <= pix_data;
    end

    ann_mac_unit #(.DATA_W(DATA_W), .FRAC_W(FRAC_W), .ACC_W(ACC_W)) u_mac (
        .clk    (clk),
        .rst    (rst),
        .clr    ((state == COMPARE) || (pix_xfer && pix_last)),
        .mac_en (coef_xfer && !is_bias),
        .pix    (pix_buf[coef_cnt[PW-1:0]]),
        .coef   (coef_data),
        .biased (biased)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_cnt     <= '0;
            coef_cnt    <= '0;
            neuron      <= '0;
            score       <= '0;
            best        <= '0;
            best_idx    <= '0;
            class_idx   <= '0;
            class_score <= '0;
        end else begin
            if (pix_xfer)
                pix_cnt <= pix_last ? '0 : pix_cnt + 1'b1;
            if (coef_xfer) begin
                coef_cnt <= is_bias ? '0 : coef_cnt + 1'b1;
                if (is_bias)
                    score <= biased;
            end
            if (state == COMPARE) begin
                // Strict compare keeps the lower index on ties.
                if (neuron == '0 || $signed(score) > $signed(best)) begin
                    best     <= score;
                    best_idx <= neuron;
                end
                if (neuron != N_LAST)
                    neuron <= neuron + 1'b1;
            end
            if (state == DONE) begin
                class_idx   <= best_idx;
                class_score <= best;
                neuron      <= '0;
            end
        end
    end

`ifdef ANN_SEVEN_SEG_EN
    logic [6:0] seg_digit;
    logic       seg_dp;

    // dp is registered from next_state so it tracks busy cycle-for-cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_digit <= '0;
            seg_dp    <= 1'b0;
        end else begin
            seg_dp <= (next_state != IDLE);
            if (state == DONE)
                seg_digit <= SEG_HEX[4'(best_idx)];
        end
    end

    assign seven_seg = {seg_dp, seg_digit};
`endif

endmodule

// File: tb/tb_ann_layer_engine.sv
// Directed bench for ann_layer_engine: hand-computed scores, latency, stalls, abort and start-while-busy.
module tb_ann_layer_engine;

    localparam int N_IN   = 64;
    localparam int N_OUT  = 16;
    localparam int DATA_W = 16;
    localparam int ACC_W  = 40;

    logic              clk = 1'b0;
    logic              rst, start, pix_valid, coef_valid;
    logic [DATA_W-1:0] pix_data, coef_data;
    logic              pix_ready, coef_ready, request_coef, busy, done;
    logic [3:0]        coef_select, class_idx;
    logic [ACC_W-1:0]  class_score;
`ifdef ANN_SEVEN_SEG_EN
    logic [7:0]        seven_seg;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ann_layer_engine dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .pix_valid    (pix_valid),
        .pix_ready    (pix_ready),
        .pix_data     (pix_data),
        .coef_valid   (coef_valid),
        .coef_ready   (coef_ready),
        .coef_data    (coef_data),
        .request_coef (request_coef),
        .coef_select  (coef_select),
        .busy         (busy),
        .done         (done),
        .class_idx    (class_idx),
        .class_score  (class_score)
`ifdef ANN_SEVEN_SEG_EN
        ,
        .seven_seg    (seven_seg)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Weight k of neuron n (k==N_IN is the bias) for each directed scenario.
    function automatic int wval(input int mode, input int n, input int k);
        case (mode)
            0:       return (k < N_IN) ? 1 : 0;
            1:       return (k < N_IN) ? ((n == 5) ? 2 : 1) : 0;
            2:       return (k < N_IN) ? -1 : ((n == 15) ? 1 : 0);
            default: return (k < N_IN) ? ((k == 2*n + 1) ? 1 : 0) : 0;
        endcase
    endfunction

    function automatic logic [7:0] seg_of(input int idx);
        case (idx)
            0:       return 8'h3F;
            5:       return 8'h6D;
            15:      return 8'h71;
            default: return 8'h00;
        endcase
    endfunction

    task automatic run_pass(input string name, input int mode, input bit stall, input bit abort,
                            input bit mid_start, input int exp_idx, input longint exp_score,
                            input int exp_lat);
        int  pk, ck, dones, done_edge, last_sel, sel_err, rdy_err, edges;
        bit  px, cx;
        pk = 0; ck = 0; dones = 0; done_edge = -1; last_sel = 0; sel_err = 0; rdy_err = 0; edges = 0;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        chk({name, "_busy_after_start"}, busy, 1);
`ifdef ANN_SEVEN_SEG_EN
        chk({name, "_seg_dp_busy"}, seven_seg[7], 1);
`endif
        for (int cyc = 0; cyc < 4000; cyc++) begin
            pix_valid  = stall ? (cyc % 2 == 0) : 1'b1;
            coef_valid = stall ? (cyc % 2 == 0) : 1'b1;
            pix_data   = (mode == 3) ? 16'(64 - pk) : 16'd1;
            coef_data  = 16'(wval(mode, int'(coef_select), ck));
            start      = mid_start && (cyc == 300);
            if (request_coef !== coef_ready) rdy_err++;
            if (dones == 0 && int'(coef_select) != last_sel) begin
                if (int'(coef_select) != last_sel + 1) sel_err++;
                last_sel = int'(coef_select);
            end
            px = pix_valid && pix_ready;
            cx = coef_valid && coef_ready;
            @(posedge clk);
            edges++;
            if (px) pk++;
            if (cx) ck = (ck == N_IN) ? 0 : ck + 1;
            #1;
            if (abort && coef_select == 4'd3 && ck == 10) begin
                rst = 1'b1;
                #1;
                chk({name, "_abort_ctl"}, {busy, done, pix_ready, coef_ready, request_coef}, 0);
                chk({name, "_abort_sel"}, coef_select, 0);
                chk({name, "_abort_idx"}, class_idx, 0);
                chk({name, "_abort_score"}, class_score, 0);
`ifdef ANN_SEVEN_SEG_EN
                chk({name, "_abort_seg"}, seven_seg, 0);
`endif
                rst = 1'b0;
                break;
            end
            if (done) begin
                dones++;
                if (done_edge < 0) done_edge = edges;
            end
            if (done_edge >= 0 && edges >= done_edge + 5) break;
        end
        pix_valid = 1'b0; coef_valid = 1'b0; start = 1'b0;
        if (!abort) begin
            chk({name, "_done_count"}, dones, 1);
            if (exp_lat > 0) chk({name, "_latency"}, done_edge, exp_lat);
            chk({name, "_pix_count"}, pk, N_IN);
            chk({name, "_class_idx"}, class_idx, exp_idx);
            chk({name, "_class_score"}, class_score, exp_score);
            chk({name, "_sel_seq"}, {sel_err[15:0], last_sel[15:0]}, {16'd0, 16'd15});
            chk({name, "_req_eq_ready"}, rdy_err, 0);
            chk({name, "_idle_after"}, busy, 0);
`ifdef ANN_SEVEN_SEG_EN
            chk({name, "_seven_seg"}, seven_seg, seg_of(exp_idx));
`endif
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; pix_valid = 1'b0; coef_valid = 1'b0;
        pix_data = '0; coef_data = '0;
        #12;
        chk("reset_ctl", {busy, done, pix_ready, coef_ready, request_coef}, 0);
        chk("reset_idx", class_idx, 0);
        chk("reset_score", class_score, 0);
        chk("reset_sel", coef_select, 0);
`ifdef ANN_SEVEN_SEG_EN
        chk("reset_seg", seven_seg, 0);
`endif
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;

        run_pass("s1_ones",      0, 1'b0, 1'b0, 1'b0, 0,  64,  1120);
        run_pass("s2_n5_double", 1, 1'b0, 1'b0, 1'b0, 5,  128, 1120);
        run_pass("s3_neg_bias",  2, 1'b0, 1'b0, 1'b0, 15, 192, 1120);
        run_pass("s7_pix_index", 3, 1'b0, 1'b0, 1'b0, 0,  63,  1120);
        run_pass("s4_stall",     1, 1'b1, 1'b0, 1'b0, 5,  128, -1);
        run_pass("s5_abort",     0, 1'b0, 1'b1, 1'b0, 0,  0,   -1);
        run_pass("s5_fresh",     0, 1'b0, 1'b0, 1'b0, 0,  64,  1120);
        run_pass("s6_mid_start", 1, 1'b0, 1'b0, 1'b1, 5,  128, 1120);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
